// File: rtl/hamming_encode_tx.sv
// Hamming(38,32) encoder with optional single-bit error injection and a
// ready/valid serialiser. One frame is 38 bits, and frames can run back-to-back.
module hamming_encode_tx #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic [5:0]  in_err_pos,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        tx_sof,
  output logic        tx_eof,
  input  logic        tx_ready,
  output logic [37:0] code_word
);

  typedef enum logic {StIdle, StShift} state_e;

  localparam logic [5:0] LastCnt = 6'd37;

  state_e      r_state, w_state_next;
  logic [5:0]  r_cnt, w_cnt_next;
  logic [37:0] r_code, w_code_next;
  logic [37:0] w_data_cw;
  logic [5:0]  w_par;
  logic [37:0] w_enc;
  logic        w_in_ready;
  logic [5:0]  w_bit_idx;

  // Scatter the payload into the non-power-of-two codeword positions.
  always_comb begin
    w_data_cw        = '0;
    w_data_cw[2]     = in_data[0];
    w_data_cw[6:4]   = in_data[3:1];
    w_data_cw[14:8]  = in_data[10:4];
    w_data_cw[30:16] = in_data[25:11];
    w_data_cw[37:32] = in_data[31:26];
  end

  // Parity k covers every position p (1-based) with bit k set; parity slots are
  // still zero in w_data_cw, so including them does not disturb the sum.
  always_comb begin
    w_par = '0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 38; i++) begin
        if ((((i + 1) >> k) & 1) != 0) begin
          w_par[k] = w_par[k] ^ w_data_cw[i];
        end
      end
    end
  end

  // Merge parity into the codeword and flip the requested bit, if any.
  always_comb begin
    w_enc     = w_data_cw;
    w_enc[0]  = w_par[0];
    w_enc[1]  = w_par[1];
    w_enc[3]  = w_par[2];
    w_enc[7]  = w_par[3];
    w_enc[15] = w_par[4];
    w_enc[31] = w_par[5];
    if ((in_err_pos != 6'd0) && (in_err_pos <= 6'd38)) begin
      w_enc[in_err_pos - 6'd1] = ~w_enc[in_err_pos - 6'd1];
    end
  end

  // Next-state logic; a new word may load on the final bit of the current frame.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_code_next  = r_code;
    w_in_ready   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_in_ready = 1'b1;
      end
      StShift: begin
        if (tx_ready) begin
          if (r_cnt == LastCnt) begin
            w_in_ready   = 1'b1;
            w_state_next = StIdle;
            w_cnt_next   = 6'd0;
          end else begin
            w_cnt_next = r_cnt + 6'd1;
          end
        end
      end
    endcase
    if (in_valid && w_in_ready) begin
      w_code_next  = w_enc;
      w_cnt_next   = 6'd0;
      w_state_next = StShift;
    end
  end

  // State registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 6'd0;
      r_code  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_code  <= w_code_next;
    end
  end

  // Outputs decode directly from the registered state so reset clears them at once.
  always_comb begin
    w_bit_idx = LSB_FIRST ? r_cnt : (LastCnt - r_cnt);
    in_ready  = w_in_ready;
    code_word = r_code;
    tx_valid  = (r_state == StShift);
    tx_sof    = tx_valid && (r_cnt == 6'd0);
    tx_eof    = tx_valid && (r_cnt == LastCnt);
    tx_bit    = tx_valid ? r_code[w_bit_idx] : 1'b0;
  end

endmodule

// File: tb/tb_hamming_encode_tx.sv
// Randomised bench for hamming_encode_tx: frame-level reference model, per-cycle
// compare on the falling edge, and a decoding scoreboard on the serial stream.
module tb_hamming_encode_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [5:0]  in_err_pos = '0;
  logic        in_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic        in_ready, tx_bit, tx_valid, tx_sof, tx_eof;
  logic [37:0] code_word;
  logic        m_in_ready, m_tx_bit, m_tx_valid, m_tx_sof, m_tx_eof;
  logic [37:0] m_code_word;

  int n_checks = 0;
  int n_fail   = 0;

  hamming_encode_tx #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_err_pos(in_err_pos),
    .in_valid(in_valid), .in_ready(in_ready), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_ready(tx_ready), .code_word(code_word)
  );

  hamming_encode_tx #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_err_pos(in_err_pos),
    .in_valid(in_valid), .in_ready(m_in_ready), .tx_bit(m_tx_bit), .tx_valid(m_tx_valid),
    .tx_sof(m_tx_sof), .tx_eof(m_tx_eof), .tx_ready(tx_ready), .code_word(m_code_word)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference encoder: walk 1-based positions, data fills non-powers of two in order.
  function automatic logic [37:0] encode(input logic [31:0] d, input logic [5:0] e);
    logic [37:0] cw;
    logic        par;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 38; p++) begin
        if (((p >> k) & 1) == 1 && (p & (p - 1)) != 0) par = par ^ cw[p-1];
      end
      cw[(1 << k) - 1] = par;
    end
    if (e >= 6'd1 && e <= 6'd38) cw[e-1] = ~cw[e-1];
    return cw;
  endfunction

  // Syndrome decoder: XOR of the positions of all set bits names the flipped bit.
  function automatic logic [31:0] decode(input logic [37:0] cw_in);
    logic [37:0] cw;
    logic [31:0] d;
    int          syn;
    int          j;
    cw  = cw_in;
    syn = 0;
    for (int p = 1; p <= 38; p++) if (cw[p-1]) syn = syn ^ p;
    if (syn >= 1 && syn <= 38) cw[syn-1] = ~cw[syn-1];
    d = '0;
    j = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p-1];
        j++;
      end
    end
    return d;
  endfunction

  // Frame-level model: busy flag, bit position, current codeword and payload.
  bit          mdl_busy = 1'b0;
  int          mdl_cnt = 0;
  logic [37:0] mdl_cw = '0;
  logic [31:0] mdl_data = '0;

  function automatic bit exp_in_ready();
    return !mdl_busy || (mdl_cnt == 37 && tx_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_busy = 1'b0;
      mdl_cnt  = 0;
      mdl_cw   = '0;
    end else begin
      bit acc;
      acc = in_valid && exp_in_ready();
      if (mdl_busy && tx_ready) begin
        if (mdl_cnt == 37) begin
          mdl_busy = 1'b0;
          mdl_cnt  = 0;
        end else begin
          mdl_cnt++;
        end
      end
      if (acc) begin
        mdl_cw   = encode(in_data, in_err_pos);
        mdl_data = in_data;
        mdl_cnt  = 0;
        mdl_busy = 1'b1;
      end
    end
  end

  int          run_len = 0;
  int          last_run = 0;
  int          sb_idx = 0;
  logic [37:0] sb_bits = '0;

  // Per-cycle compare, valid-run measurement and decoding scoreboard.
  always @(negedge clk) begin
    logic e_bit, e_mbit;
    e_bit  = mdl_busy ? mdl_cw[mdl_cnt] : 1'b0;
    e_mbit = mdl_busy ? mdl_cw[37 - mdl_cnt] : 1'b0;
    check("in_ready", in_ready, exp_in_ready());
    check("tx_valid", tx_valid, mdl_busy);
    check("tx_sof", tx_sof, mdl_busy && mdl_cnt == 0);
    check("tx_eof", tx_eof, mdl_busy && mdl_cnt == 37);
    check("tx_bit", tx_bit, e_bit);
    check("code_word", code_word, mdl_cw);
    check("msb_tx_bit", m_tx_bit, e_mbit);
    check("msb_valid", {m_in_ready, m_tx_valid, m_tx_sof, m_tx_eof},
          {in_ready, tx_valid, tx_sof, tx_eof});
    check("msb_code_word", m_code_word, mdl_cw);
    if (tx_valid) begin
      run_len++;
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
    if (rst) begin
      sb_idx = 0;
    end else if (tx_valid && tx_ready) begin
      if (tx_sof) sb_idx = 0;
      if (sb_idx < 38) sb_bits[sb_idx] = tx_bit;
      sb_idx++;
      if (tx_eof) begin
        check("sb_len", sb_idx, 38);
        check("sb_decode", decode(sb_bits), mdl_data);
      end
    end
  end

  bit rnd_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic offer(input logic [31:0] d, input logic [5:0] e);
    int n;
    in_data    = d;
    in_err_pos = e;
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    if (!in_ready) timeout_fail("offer");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_valid && n < 500) begin
      tick();
      n++;
    end
    if (tx_valid) timeout_fail("wait_idle");
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic saved;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_code_word", code_word, 38'h0);
    rst = 1'b0;

    // Hand-computed codewords pin the reference encoder.
    check("enc_zero", encode(32'h0, 6'd0), 38'h0);
    check("enc_ones", encode(32'hFFFF_FFFF, 6'd0), 38'h3F_7FFF_FFF4);
    check("enc_one", encode(32'h1, 6'd0), 38'h7);
    check("enc_one_err5", encode(32'h1, 6'd5), 38'h17);
    check("enc_one_err39", encode(32'h1, 6'd39), 38'h7);

    tx_ready = 1'b1;
    offer(32'h0, 6'd0);
    check("zero_sof", tx_sof, 1'b1);
    wait_idle();
    check("zero_len", last_run, 38);

    offer(32'hFFFF_FFFF, 6'd0);
    check("ones_cw", code_word, 38'h3F_7FFF_FFF4);
    check("ones_bit0", tx_bit, 1'b0);
    wait_idle();

    offer(32'h1, 6'd5);
    check("err5_cw", code_word, 38'h17);
    wait_idle();

    // Back-to-back pair: one unbroken 76-cycle valid run.
    offer(32'h1, 6'd39);
    check("err39_cw", code_word, 38'h7);
    offer(32'hA5A5_5A5A, 6'd0);
    check("b2b_sof", tx_sof, 1'b1);
    wait_idle();
    check("b2b_len", last_run, 76);

    // Back-pressure for five cycles at bit 10.
    offer(32'h1234_5678, 6'd17);
    repeat (10) tick();
    tx_ready = 1'b0;
    saved = tx_bit;
    repeat (5) begin
      tick();
      check("stall_bit", tx_bit, saved);
    end
    tx_ready = 1'b1;
    wait_idle();
    check("stall_len", last_run, 43);

    // Reset mid-frame aborts without waiting for a clock.
    offer(32'hDEAD_BEEF, 6'd0);
    repeat (20) tick();
    check("pre_rst_valid", tx_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_abort_valid", tx_valid, 1'b0);
    check("rst_abort_ready", in_ready, 1'b1);
    tick();
    rst = 1'b0;
    offer(32'hCAFE_F00D, 6'd38);
    check("post_rst_sof", tx_sof, 1'b1);
    check("post_rst_cw", code_word, encode(32'hCAFE_F00D, 6'd38));
    wait_idle();

    // Random payloads, injection positions and sink stalls.
    rnd_ready = 1'b1;
    for (int f = 0; f < 60; f++) begin
      logic [5:0] e;
      e = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(39, 63)) : 6'($urandom_range(0, 38));
      offer($urandom, e);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 50)) tick();
    end
    rnd_ready = 1'b0;
    tx_ready  = 1'b1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_encode_tx.md
HAMMING_ENCODE_TX -- requirements
Module: hamming_encode_tx

Interface
REQ-001 Parameter: LSB_FIRST, default 1, serial order (1: codeword index 0 first; 0: index 37 first).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_data  input  32  payload word.
REQ-005 in_err_pos  input  6  error-injection position, sampled with in_data; 0 = no injection.
REQ-006 in_valid  input  1  payload offer.
REQ-007 in_ready  output  1  block accepts payload this cycle.
REQ-008 tx_bit  output  1  current serial codeword bit.
REQ-009 tx_valid  output  1  tx_bit is a live frame bit.
REQ-010 tx_sof  output  1  high with the first bit of each frame.
REQ-011 tx_eof  output  1  high with the last (38th) bit of each frame.
REQ-012 tx_ready  input  1  sink consumes tx_bit this cycle.
REQ-013 code_word  output  38  codeword of the frame in flight, held until next accept.

Function
REQ-014 The codeword SHALL use 1-based positions p = index+1; parity bits at indices 0,1,3,7,15,31; data bits in order: in_data[0]->idx 2, [3:1]->idx 6:4, [10:4]->idx 14:8, [25:11]->idx 30:16, [31:26]->idx 37:32.
REQ-015 Parity at index 2^k-1 (k=0..5) SHALL be the XOR of all data bits whose position p has bit k set, giving an all-zero syndrome for an uncorrupted codeword.
REQ-016 If 1 <= in_err_pos <= 38, the captured codeword SHALL have index in_err_pos-1 inverted; values 0 and 39..63 SHALL inject nothing.
REQ-017 The FSM SHALL have states IDLE and SHIFT, with a 6-bit bit counter cnt (0..37).
REQ-018 in_ready SHALL be 1 in IDLE, and 1 in SHIFT only when cnt==37 and tx_ready==1; it SHALL be 0 otherwise.
REQ-019 On an edge with in_valid&in_ready, the block SHALL register the encoded (and injected) codeword into code_word, set cnt=0, and enter SHIFT.
REQ-020 In SHIFT, tx_valid SHALL be 1, and tx_bit SHALL be code_word[cnt] (LSB_FIRST=1) or code_word[37-cnt] (LSB_FIRST=0).
REQ-021 tx_sof SHALL be (SHIFT & cnt==0); tx_eof SHALL be (SHIFT & cnt==37).
REQ-022 In SHIFT with tx_ready=0, cnt, tx_bit and all outputs SHALL hold.
REQ-023 In SHIFT with tx_ready=1 and cnt<37, cnt SHALL increment.
REQ-024 In SHIFT with tx_ready=1, cnt==37 and in_valid=1 (back-to-back), the next frame SHALL load and start at cnt=0 the next cycle with no gap.
REQ-025 In SHIFT with tx_ready=1, cnt==37 and in_valid=0, the FSM SHALL return to IDLE.
REQ-026 In IDLE, tx_valid, tx_sof, tx_eof and tx_bit SHALL be 0, and code_word SHALL hold its last value.
REQ-027 Latency: the first frame bit SHALL appear one cycle after the accepting edge; a frame SHALL take exactly 38 tx_ready-qualified cycles.

Reset
REQ-028 While rst=1, the state SHALL be IDLE, cnt 0, code_word 0, tx_valid/tx_sof/tx_eof/tx_bit 0, and in_ready 1; handshakes during rst SHALL be ignored.
REQ-029 rst asserted mid-frame SHALL abort the frame immediately (tx_valid falls without waiting for a clock); the partial frame SHALL NOT resume after rst deasserts.

Verification
REQ-030 in_data=32'h0, err_pos=0 -> code_word=38'h0; 38 zero bits; tx_sof on bit 0, tx_eof on bit 37.
REQ-031 in_data=32'hFFFFFFFF -> code_word=38'h3F7FFFFFF4; LSB_FIRST=1 serial order begins 0,0,1,0,1...
REQ-032 in_data=32'h1 -> code_word=38'h7; with in_err_pos=5 -> 38'h17; with in_err_pos=39 -> 38'h7.
REQ-033 Two words offered back-to-back with tx_ready=1 -> 76 consecutive tx_valid cycles; in_ready=1 only on the cnt==37 cycle; second tx_sof immediately follows first tx_eof.
REQ-034 tx_ready held 0 for 5 cycles at cnt=10 -> tx_bit/cnt frozen; the frame completes in 43 cycles total.
REQ-035 rst pulsed at cnt=20 -> tx_valid=0 at once, in_ready=1; the next accepted word starts a fresh frame with tx_sof.
REQ-036 Scoreboard: loop every tx frame through the 38-to-32 decoder for random data and err_pos 0..38 -> decoded word equals in_data in all cases.
